// File: rtl/data_sync_source.sv
// Source end of a din/dready link: buffers an upstream stream in a small FIFO and
// presents each word with setup/strobe/hold framing. Optional 4-phase ack via DSRC_ACK_EN.
module data_sync_source #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [DATA_W-1:0]             dout,
  output logic                          dready_o,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
`ifdef DSRC_ACK_EN
  ,
  input  logic                          ack_i
`endif
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CMAX = (SETUP_CYC > STROBE_CYC) ?
                        ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                        ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] L_SETUP  = CW'(SETUP_CYC);
  localparam logic [CW-1:0] L_STROBE = CW'(STROBE_CYC);
  localparam logic [CW-1:0] L_HOLD   = CW'(HOLD_CYC);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  state_t            r_state;
  logic [CW-1:0]     r_cnt;

  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_expire;
  logic w_ack_hi;
  logic w_ack_lo;

  assign w_full   = (r_count == (AW+1)'(FIFO_DEPTH));
  assign s_ready  = !w_full && !rst;
  assign w_push   = s_valid && s_ready;
  assign w_pop    = (r_state == ST_IDLE) && (r_count != '0);
  assign w_expire = (r_cnt <= CW'(1));
  assign fifo_cnt = r_count;
  assign busy     = (r_state != ST_IDLE) || (r_count != '0);

`ifdef DSRC_ACK_EN
  assign w_ack_hi = ack_i;
  assign w_ack_lo = !ack_i;
`else
  assign w_ack_hi = 1'b1;
  assign w_ack_lo = 1'b1;
`endif

  // FIFO storage: data only, never reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 depth
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Framing FSM: the shared down-counter is reloaded on every state entry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      dout     <= '0;
      dready_o <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            dout    <= r_mem[r_rd_ptr];
            r_cnt   <= L_SETUP;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (w_expire) begin
            r_cnt    <= L_STROBE;
            r_state  <= ST_STROBE;
            dready_o <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_STROBE: begin
          // counter parks at 1 once the minimum width is met and waits for ack
          if (w_expire && w_ack_hi) begin
            r_cnt    <= L_HOLD;
            r_state  <= ST_HOLD;
            dready_o <= 1'b0;
          end else if (!w_expire) begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_HOLD: begin
          if (w_expire && w_ack_lo) begin
            r_state <= ST_IDLE;
          end else if (!w_expire) begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_sync_source.sv
// Directed bench for data_sync_source: reset, single word, back-to-back, full FIFO,
// reset mid-strobe, and (with DSRC_ACK_EN) the ack handshake.
module tb_data_sync_source;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] dout;
  logic       dready_o;
  logic       busy;
  logic [2:0] fifo_cnt;
  logic       auto_ack;
  logic       ack_man;
  logic       ack_w;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] cap_q [$];
  int         rise_q [$];
  int         width_q [$];
  logic       prev_rdy = 1'b0;
  logic [7:0] strobe_word;
  int         width;

  assign ack_w = auto_ack ? dready_o : ack_man;

  data_sync_source dut (
    .clk      (clk),
    .rst      (rst),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .dout     (dout),
    .dready_o (dready_o),
    .busy     (busy),
    .fifo_cnt (fifo_cnt)
`ifdef DSRC_ACK_EN
    ,
    .ack_i    (ack_w)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: records each word at dready_o rise and checks it stays put while high
  always @(negedge clk) begin
    if (dready_o === 1'b1 && prev_rdy !== 1'b1) begin
      cap_q.push_back(dout);
      rise_q.push_back(cyc);
      strobe_word = dout;
      width = 1;
    end else if (dready_o === 1'b1) begin
      width++;
      checks++;
      if (dout !== strobe_word) begin
        failures++;
        $display("FAIL strobe_stable: dout=%h required %h", dout, strobe_word);
      end
    end
    if (dready_o !== 1'b1 && prev_rdy === 1'b1) width_q.push_back(width);
    prev_rdy = dready_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    cap_q.delete();
    rise_q.delete();
    width_q.delete();
  endtask

  task automatic wait_idle(input int bound, input string name);
    for (int i = 0; i < bound && busy; i++) tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_timeout: busy=%b required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b1; s_data = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (s_ready !== 1'b0 || dout !== 8'h00 || dready_o !== 1'b0 ||
          fifo_cnt !== 3'd0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_state: s_ready=%b dout=%h dready=%b cnt=%0d busy=%b required 0/00/0/0/0",
                 s_ready, dout, dready_o, fifo_cnt, busy);
      end
    end
    rst = 1'b0; s_valid = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b1 || fifo_cnt !== 3'd0) begin
      failures++;
      $display("FAIL reset_release: s_ready=%b cnt=%0d required 1/0", s_ready, fifo_cnt);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp_dout [8];
    logic       exp_rdy  [8];
    clear_mon();
    exp_dout = '{8'h00, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
    exp_rdy  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    s_data = 8'hAA; s_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      s_valid = 1'b0;
      checks++;
      if (dout !== exp_dout[k] || dready_o !== exp_rdy[k]) begin
        failures++;
        $display("FAIL single_t%0d: dout=%h dready=%b required %h/%b",
                 k, dout, dready_o, exp_dout[k], exp_rdy[k]);
      end
      if (k == 0) begin
        checks++;
        if (fifo_cnt !== 3'd1 || busy !== 1'b1) begin
          failures++;
          $display("FAIL single_push: cnt=%0d busy=%b required 1/1", fifo_cnt, busy);
        end
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL single_done: busy=%b required 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [4];
    words = '{8'hAA, 8'h55, 8'hFF, 8'h00};
    clear_mon();
    for (int k = 0; k < 4; k++) begin
      s_data = words[k]; s_valid = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    wait_idle(60, "b2b");
    checks++;
    if (cap_q.size() != 4 || width_q.size() != 4) begin
      failures++;
      $display("FAIL b2b_count: words=%0d pulses=%0d required 4/4", cap_q.size(), width_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (cap_q[k] !== words[k] || width_q[k] != 2) begin
          failures++;
          $display("FAIL b2b_word%0d: dout=%h width=%0d required %h/2", k, cap_q[k], width_q[k], words[k]);
        end
        if (k > 0) begin
          checks++;
          if (rise_q[k] - rise_q[k-1] != 7) begin
            failures++;
            $display("FAIL b2b_gap%0d: gap=%0d required 7", k, rise_q[k] - rise_q[k-1]);
          end
        end
      end
    end
  endtask

  task automatic test_full();
    logic [2:0] exp_cnt [10];
    logic [7:0] d;
    logic       acc;
    exp_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd3, 3'd4};
    clear_mon();
    d = 8'h10;
    s_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      s_data = d;
      acc = s_ready;
      tick();
      if (acc) d = d + 8'd1;
      checks++;
      if (fifo_cnt !== exp_cnt[k] || s_ready !== (exp_cnt[k] != 3'd4)) begin
        failures++;
        $display("FAIL full_c%0d: cnt=%0d s_ready=%b required %0d/%b",
                 k, fifo_cnt, s_ready, exp_cnt[k], exp_cnt[k] != 3'd4);
      end
    end
    s_valid = 1'b0;
    wait_idle(80, "full");
    checks++;
    if (cap_q.size() != 6) begin
      failures++;
      $display("FAIL full_count: words=%0d required 6", cap_q.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (cap_q[k] !== 8'h10 + 8'(k)) begin
          failures++;
          $display("FAIL full_word%0d: dout=%h required %h", k, cap_q[k], 8'h10 + 8'(k));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] words [3];
    words = '{8'hA1, 8'hA2, 8'hA3};
    clear_mon();
    for (int k = 0; k < 3; k++) begin
      s_data = words[k]; s_valid = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    for (int i = 0; i < 20 && dready_o !== 1'b1; i++) tick();
    checks++;
    if (dready_o !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_strobe: dready=%b required 1", dready_o);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (dready_o !== 1'b0 || dout !== 8'h00 || fifo_cnt !== 3'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_state: dready=%b dout=%h cnt=%0d busy=%b required 0/00/0/0",
               dready_o, dout, fifo_cnt, busy);
    end
    rst = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    checks++;
    if (cap_q.size() != 1 || dout !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_discard: words=%0d dout=%h busy=%b required 1/00/0",
               cap_q.size(), dout, busy);
    end
  endtask

`ifdef DSRC_ACK_EN
  task automatic test_ack();
    clear_mon();
    auto_ack = 1'b0; ack_man = 1'b0;
    s_data = 8'hB1; s_valid = 1'b1;
    tick();
    s_data = 8'hB2;
    tick();
    s_valid = 1'b0;
    for (int i = 0; i < 20 && dready_o !== 1'b1; i++) tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (dready_o !== 1'b1) begin
        failures++;
        $display("FAIL ack_wait%0d: dready=%b required 1", i, dready_o);
      end
    end
    ack_man = 1'b1;
    tick();
    checks++;
    if (dready_o !== 1'b0) begin
      failures++;
      $display("FAIL ack_fall: dready=%b required 0", dready_o);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (dready_o !== 1'b0 || dout !== 8'hB1 || fifo_cnt !== 3'd1) begin
        failures++;
        $display("FAIL ack_hold%0d: dready=%b dout=%h cnt=%0d required 0/b1/1",
                 i, dready_o, dout, fifo_cnt);
      end
    end
    ack_man = 1'b0;
    tick();
    tick();
    checks++;
    if (dout !== 8'hB2 || fifo_cnt !== 3'd0) begin
      failures++;
      $display("FAIL ack_next: dout=%h cnt=%0d required b2/0", dout, fifo_cnt);
    end
    auto_ack = 1'b1;
    wait_idle(40, "ack");
  endtask
`endif

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00;
    auto_ack = 1'b1; ack_man = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_reset_mid();
`ifdef DSRC_ACK_EN
    test_ack();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
